if_prefetch: RTL and testbench
==============================

# if_prefetch

Parametrised instruction-fetch stage with a prefetch queue, replacing the single-slot fetch path of the RISC-V core. It issues one aligned 32-bit fetch per cycle to one of two synchronous-read instruction memories (BIOS / IMEM), buffers returned words with their PC in a QUEUE_DEPTH-entry FIFO, and hands them to decode over a valid/ready handshake. Jump/branch redirects flush the queue and kill in-flight reads.

## Interface
- RST_PC, 32'h4000_0000, fetch address after reset (bits [1:0] must be 0)
- QUEUE_DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- MEM0_TAG, 4'h4, pc[31:28] value selecting memory 0 (BIOS)
- MEM1_TAG, 4'h1, pc[31:28] value selecting memory 1 (IMEM)
- MEM0_AW, 12, memory 0 word-address width
- MEM1_AW, 14, memory 1 word-address width
- clk  in  1  core clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- jump_valid  in  1  redirect request from execute
- jump_addr  in  32  redirect target; bits [1:0] ignored (treated as 0)
- mem0_en  out  1  memory 0 read enable
- mem0_addr  out  MEM0_AW  = fetch_pc[MEM0_AW+1:2]
- mem0_data  in  32  memory 0 read data, valid one cycle after mem0_en
- mem1_en  out  1  memory 1 read enable
- mem1_addr  out  MEM1_AW  = fetch_pc[MEM1_AW+1:2]
- mem1_data  in  32  memory 1 read data, valid one cycle after mem1_en
- out_valid  out  1  queue head valid to decode
- out_ready  in  1  decode accepts head
- out_inst  out  32  head instruction word
- out_pc  out  32  head PC
- out_fault  out  1  head fetched from an unmapped address (out_inst = 0)

## Operation
- Registers: pc_r (next sequential fetch PC), in-flight slot (valid, kill, pc, region: mem0/mem1/none), FIFO (inst, pc, fault) with rd/wr pointers and count.
- fetch_pc (combinational): rst → RST_PC; jump_valid → {jump_addr[31:2],2'b00}; else pc_r.
- Issue condition: !rst && (jump_valid || count + inflight_valid < QUEUE_DEPTH). Credit ignores same-cycle pop (conservative).
- On issue: assert mem0_en if fetch_pc[31:28]==MEM0_TAG, mem1_en if ==MEM1_TAG, neither otherwise (unmapped); load in-flight slot (valid=1, kill=0); pc_r <= fetch_pc + 4. No issue: enables low, pc_r held, in-flight valid cleared.
- Response cycle: if in-flight valid && !kill && !jump_valid, push {selected mem data, or 0 if unmapped; pc; fault=unmapped}.
- Redirect (jump_valid): FIFO count→0 and pointers reset; any response returning this cycle discarded; fetch at target issued the same cycle. out_valid forced 0 combinationally in that cycle; no pop occurs.
- Pop when out_valid && out_ready. Push and pop in the same cycle leave count unchanged. Push never occurs when full (guaranteed by credit).
- Address arithmetic modulo 2^32; pc 32'hFFFF_FFFC + 4 wraps to 0 (unmapped → fault).

## Timing
- During rst: mem0_en=mem1_en=0, out_valid=0, out_inst=0, out_pc=0, out_fault=0, count=0, in-flight invalid, pc_r<=RST_PC. Reset asserted mid-stream discards queue and in-flight data on the next edge.
- First cycle after rst falls (T0): fetch RST_PC issued. T1: data pushed. T2: out_valid=1, out_pc=RST_PC.
- Issue-to-out_valid latency 2 cycles (no bypass). Redirect at T issues target at T; target visible on out_* at T+2.
- Sustained throughput 1 instr/cycle with out_ready=1 requires QUEUE_DEPTH ≥ 4; QUEUE_DEPTH=2 gives ≥1 per 2 cycles.
- out_* driven from FIFO head registers; stable while out_valid && !out_ready (except redirect).

## Test plan
- Reset release, RST_PC=32'h4000_0000, out_ready=1, mem0 returns addr-derived data → out_valid at T2, out_pc sequence 4000_0000, 4000_0004, … one per cycle, mem0_addr 0,1,2….
- out_ready=0 for 10 cycles → exactly QUEUE_DEPTH entries held, mem enables low once credit exhausted, no PC skipped or duplicated on resume.
- jump_valid with jump_addr=32'h1000_0010 while queue full and a read in flight → out_valid=0 that cycle, mem1_en=1, mem1_addr=4; next out_pc=1000_0010 two cycles later, no stale entries.
- Back-to-back jumps (1000_0000 then 4000_0100) on consecutive cycles → only 4000_0100 stream emerges.
- Fetch at 32'h2000_0000 → no mem enable, out_fault=1, out_inst=0, out_pc=2000_0000.
- rst asserted with queue half full → next cycle out_valid=0, count 0; refetch starts at RST_PC.

Source files
------------

// File: rtl/if_prefetch_if.sv
// -----------------------------------------------------------------------------
// if_prefetch_if
// Bundle of the fetch stage's external signals.
//   jump_valid/jump_addr         : redirect request from execute
//   mem0_en/mem0_addr/mem0_data  : memory 0 (BIOS) synchronous read port
//   mem1_en/mem1_addr/mem1_data  : memory 1 (IMEM) synchronous read port
//   out_valid/out_ready          : valid/ready handshake towards decode
//   out_inst/out_pc/out_fault    : queue head payload
// The master modport is the fetch stage; the slave modport is its environment
// (execute, the two memories and decode).
// -----------------------------------------------------------------------------
interface if_prefetch_if #(
    parameter int MEM0_AW = 12,
    parameter int MEM1_AW = 14
);
    logic               jump_valid;
    logic [31:0]        jump_addr;
    logic               mem0_en;
    logic [MEM0_AW-1:0] mem0_addr;
    logic [31:0]        mem0_data;
    logic               mem1_en;
    logic [MEM1_AW-1:0] mem1_addr;
    logic [31:0]        mem1_data;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_inst;
    logic [31:0]        out_pc;
    logic               out_fault;

    modport master (
        input  jump_valid, jump_addr, mem0_data, mem1_data, out_ready,
        output mem0_en, mem0_addr, mem1_en, mem1_addr,
               out_valid, out_inst, out_pc, out_fault
    );

    modport slave (
        output jump_valid, jump_addr, mem0_data, mem1_data, out_ready,
        input  mem0_en, mem0_addr, mem1_en, mem1_addr,
               out_valid, out_inst, out_pc, out_fault
    );
endinterface

// File: rtl/if_prefetch.sv
// -----------------------------------------------------------------------------
// if_prefetch
// Instruction-fetch stage with a prefetch queue. Issues one aligned 32-bit
// fetch per cycle to one of two synchronous-read memories chosen by pc[31:28],
// buffers the returned words with their PC in a QUEUE_DEPTH-entry FIFO and
// presents the head to decode over valid/ready. A redirect empties the queue,
// discards the read returning that cycle and fetches the target at once.
// Ports:
//   clk  : core clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : if_prefetch_if master (redirect, memory ports, decode handshake)
// -----------------------------------------------------------------------------
module if_prefetch #(
    parameter logic [31:0] RST_PC      = 32'h4000_0000,
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [3:0]  MEM0_TAG    = 4'h4,
    parameter logic [3:0]  MEM1_TAG    = 4'h1,
    parameter int          MEM0_AW     = 12,
    parameter int          MEM1_AW     = 14
) (
    input  logic          clk,
    input  logic          rst,
    if_prefetch_if.master bus
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        REGION_NONE = 2'd0,
        REGION_MEM0 = 2'd1,
        REGION_MEM1 = 2'd2
    } region_t;

    // Sequential fetch state
    logic [31:0] pc_reg;
    logic        infl_valid_reg;
    logic [31:0] infl_pc_reg;
    region_t     infl_region_reg;

    // Prefetch FIFO
    logic [31:0] fifo_inst [QUEUE_DEPTH];
    logic [31:0] fifo_pc   [QUEUE_DEPTH];
    logic        fifo_fault[QUEUE_DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;

    logic [31:0] fetch_pc;
    region_t     fetch_region;
    logic        credit_ok;
    logic        issue;
    logic        push;
    logic [31:0] push_inst;
    logic        push_fault;
    logic        head_valid;
    logic        pop;

    // Low address bits of the redirect target are dropped on purpose.
    logic unused_jump_bits;
    assign unused_jump_bits = &{1'b0, bus.jump_addr[1:0]};

    always_comb begin
        fetch_pc = pc_reg;
        if (rst) begin
            fetch_pc = RST_PC;
        end else if (bus.jump_valid) begin
            fetch_pc = {bus.jump_addr[31:2], 2'b00};
        end
    end

    always_comb begin
        fetch_region = REGION_NONE;
        if (fetch_pc[31:28] == MEM0_TAG) begin
            fetch_region = REGION_MEM0;
        end else if (fetch_pc[31:28] == MEM1_TAG) begin
            fetch_region = REGION_MEM1;
        end
    end

    // Credit counts queued entries plus the read still in flight, and does not
    // take a same-cycle pop into account, so a push can never hit a full FIFO.
    assign credit_ok = (count_reg + CW'(infl_valid_reg)) < CW'(QUEUE_DEPTH);
    assign issue     = !rst && (bus.jump_valid || credit_ok);

    assign bus.mem0_en   = issue && (fetch_region == REGION_MEM0);
    assign bus.mem1_en   = issue && (fetch_region == REGION_MEM1);
    assign bus.mem0_addr = fetch_pc[MEM0_AW+1:2];
    assign bus.mem1_addr = fetch_pc[MEM1_AW+1:2];

    // A redirect in the response cycle means the returning word is stale.
    assign push = infl_valid_reg && !bus.jump_valid && !rst;

    always_comb begin
        push_inst  = 32'h0;
        push_fault = 1'b0;
        case (infl_region_reg)
            REGION_MEM0: push_inst  = bus.mem0_data;
            REGION_MEM1: push_inst  = bus.mem1_data;
            default:     push_fault = 1'b1;
        endcase
    end

    assign head_valid    = (count_reg != '0);
    assign bus.out_valid = head_valid && !bus.jump_valid && !rst;
    assign pop           = bus.out_valid && bus.out_ready;

    assign bus.out_inst  = rst ? 32'h0 : fifo_inst[rd_ptr_reg];
    assign bus.out_pc    = rst ? 32'h0 : fifo_pc[rd_ptr_reg];
    assign bus.out_fault = rst ? 1'b0  : fifo_fault[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg          <= RST_PC;
            infl_valid_reg  <= 1'b0;
            infl_pc_reg     <= 32'h0;
            infl_region_reg <= REGION_NONE;
        end else if (issue) begin
            pc_reg          <= fetch_pc + 32'd4;
            infl_valid_reg  <= 1'b1;
            infl_pc_reg     <= fetch_pc;
            infl_region_reg <= fetch_region;
        end else begin
            infl_valid_reg  <= 1'b0;
        end
    end

    // FIFO storage carries no reset; occupancy is tracked by count_reg.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr_reg]  <= push_inst;
            fifo_pc[wr_ptr_reg]    <= infl_pc_reg;
            fifo_fault[wr_ptr_reg] <= push_fault;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.jump_valid) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (!push && pop) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_if_prefetch.sv
// -----------------------------------------------------------------------------
// tb_if_prefetch
// Drives reset/redirect/ready stimulus into if_prefetch, models both memories,
// and checks every accepted instruction against an expected stream: after each
// reset or redirect the expected output is the sequence start, start+4, ...
// with the word each memory holds at that address (zero and fault when the
// address is unmapped).
// -----------------------------------------------------------------------------
module tb_if_prefetch;
    localparam logic [31:0] RST_PC = 32'h4000_0000;
    localparam int          QD     = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;
    exp_t expq[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    if_prefetch_if #(.MEM0_AW(12), .MEM1_AW(14)) bus ();

    if_prefetch #(
        .RST_PC(RST_PC), .QUEUE_DEPTH(QD), .MEM0_TAG(4'h4), .MEM1_TAG(4'h1),
        .MEM0_AW(12), .MEM1_AW(14)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [31:0] mem0_word(input logic [11:0] a);
        return 32'hB105_0000 ^ {20'h0, a} ^ ({20'h0, a} << 16);
    endfunction

    function automatic logic [31:0] mem1_word(input logic [13:0] a);
        return 32'h1AA0_0000 ^ {18'h0, a} ^ ({18'h0, a} << 17);
    endfunction

    // Synchronous-read memories: data one cycle after the enable.
    always @(posedge clk) begin
        if (bus.mem0_en) bus.mem0_data <= mem0_word(bus.mem0_addr);
        if (bus.mem1_en) bus.mem1_data <= mem1_word(bus.mem1_addr);
    end

    function automatic exp_t ref_fetch(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.inst  = 32'h0;
        e.fault = 1'b1;
        if (pc[31:28] == 4'h4) begin
            e.inst  = mem0_word(pc[13:2]);
            e.fault = 1'b0;
        end else if (pc[31:28] == 4'h1) begin
            e.inst  = mem1_word(pc[15:2]);
            e.fault = 1'b0;
        end
        return e;
    endfunction

    task automatic restart_stream(input logic [31:0] start);
        logic [31:0] p;
        expq.delete();
        p = {start[31:2], 2'b00};
        for (int i = 0; i < 1024; i++) begin
            expq.push_back(ref_fetch(p));
            p = p + 32'd4;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the expected stream on every accepted instruction.
    always @(negedge clk) begin
        if (!rst && bus.jump_valid) begin
            checks++;
            if (bus.out_valid) begin
                errors++;
                $display("FAIL redirect_out_valid actual=1 required=0");
            end
        end
        if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output pc=%h with no expected entry", bus.out_pc);
            end else begin
                mon_e = expq.pop_front();
                pops++;
                if (bus.out_pc !== mon_e.pc || bus.out_inst !== mon_e.inst ||
                    bus.out_fault !== mon_e.fault) begin
                    errors++;
                    $display("FAIL stream actual pc=%h inst=%h fault=%0d required pc=%h inst=%h fault=%0d",
                             bus.out_pc, bus.out_inst, bus.out_fault,
                             mon_e.pc, mon_e.inst, mon_e.fault);
                end else begin
                    $display("pop pc=%h inst=%h fault=%0d", bus.out_pc, bus.out_inst, bus.out_fault);
                end
            end
        end
    end

    initial begin
        logic [31:0] tgt;
        int r;
        rst            = 1'b1;
        bus.jump_valid = 1'b0;
        bus.jump_addr  = 32'h0;
        bus.out_ready  = 1'b1;
        restart_stream(RST_PC);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem0_en",   32'(bus.mem0_en),   32'd0);
        chk("rst_mem1_en",   32'(bus.mem1_en),   32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_inst",  bus.out_inst,       32'd0);
        chk("rst_out_pc",    bus.out_pc,         32'd0);
        chk("rst_out_fault", 32'(bus.out_fault), 32'd0);

        // Reset release: T0 issue, T1 push, T2 visible
        tick; rst = 1'b0;
        @(negedge clk);
        chk("t0_mem0_en",   32'(bus.mem0_en),   32'd1);
        chk("t0_mem0_addr", 32'(bus.mem0_addr), 32'd0);
        chk("t0_mem1_en",   32'(bus.mem1_en),   32'd0);
        chk("t0_out_valid", 32'(bus.out_valid), 32'd0);
        tick; @(negedge clk);
        chk("t1_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t1_mem0_addr", 32'(bus.mem0_addr), 32'd1);
        tick; @(negedge clk);
        chk("t2_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_out_pc",    bus.out_pc,         RST_PC);
        for (int i = 0; i < 8; i++) begin
            tick; @(negedge clk);
            chk("stream_valid", 32'(bus.out_valid), 32'd1);
            chk("stream_addr",  32'(bus.mem0_addr), 32'(3 + i));
        end

        // Back-pressure until credit is exhausted
        tick; bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 9) begin
                chk("stall_mem0_en",   32'(bus.mem0_en),   32'd0);
                chk("stall_mem1_en",   32'(bus.mem1_en),   32'd0);
                chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_head_pc",   bus.out_pc,         expq[0].pc);
            end
            tick;
        end

        // Redirect into memory 1 with a full queue; low bits must be ignored
        bus.jump_valid = 1'b1; bus.jump_addr = 32'h1000_0012;
        restart_stream(32'h1000_0010);
        @(negedge clk);
        chk("jmp_out_valid", 32'(bus.out_valid), 32'd0);
        chk("jmp_mem1_en",   32'(bus.mem1_en),   32'd1);
        chk("jmp_mem1_addr", 32'(bus.mem1_addr), 32'd4);
        chk("jmp_mem0_en",   32'(bus.mem0_en),   32'd0);
        tick; bus.jump_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("jmp1_out_valid", 32'(bus.out_valid), 32'd0);
        tick; @(negedge clk);
        chk("jmp2_out_valid", 32'(bus.out_valid), 32'd1);
        chk("jmp2_out_pc",    bus.out_pc,         32'h1000_0010);

        // Stall and resume without redirect: stream must continue unbroken
        tick; bus.out_ready = 1'b0;
        repeat (10) tick;
        bus.out_ready = 1'b1;
        repeat (12) tick;

        // Back-to-back redirects
        bus.jump_valid = 1'b1; bus.jump_addr = 32'h1000_0000;
        restart_stream(32'h1000_0000);
        tick; bus.jump_addr = 32'h4000_0100;
        restart_stream(32'h4000_0100);
        @(negedge clk);
        chk("b2b_mem0_addr", 32'(bus.mem0_addr), 32'h40);
        tick; bus.jump_valid = 1'b0;
        @(negedge clk);
        chk("b2b1_out_valid", 32'(bus.out_valid), 32'd0);
        tick; @(negedge clk);
        chk("b2b2_out_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b2_out_pc",    bus.out_pc,         32'h4000_0100);

        // Unmapped fetch
        tick; bus.jump_valid = 1'b1; bus.jump_addr = 32'h2000_0000;
        restart_stream(32'h2000_0000);
        @(negedge clk);
        chk("unm_mem0_en", 32'(bus.mem0_en), 32'd0);
        chk("unm_mem1_en", 32'(bus.mem1_en), 32'd0);
        tick; bus.jump_valid = 1'b0;
        tick; @(negedge clk);
        chk("unm_out_valid", 32'(bus.out_valid), 32'd1);
        chk("unm_out_fault", 32'(bus.out_fault), 32'd1);
        chk("unm_out_inst",  bus.out_inst,       32'd0);
        chk("unm_out_pc",    bus.out_pc,         32'h2000_0000);

        // Reset with a partly filled queue
        tick; bus.out_ready = 1'b0;
        tick; tick;
        rst = 1'b1;
        restart_stream(RST_PC);
        @(negedge clk);
        chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_mem0_en",   32'(bus.mem0_en),   32'd0);
        chk("mrst_mem1_en",   32'(bus.mem1_en),   32'd0);
        tick; rst = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("mrst_t0_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_t0_mem0_en",   32'(bus.mem0_en),   32'd1);
        chk("mrst_t0_mem0_addr", 32'(bus.mem0_addr), 32'd0);
        tick; tick; @(negedge clk);
        chk("mrst_t2_out_valid", 32'(bus.out_valid), 32'd1);
        chk("mrst_t2_out_pc",    bus.out_pc,         RST_PC);

        // Address wrap at the top of the space
        tick; bus.jump_valid = 1'b1; bus.jump_addr = 32'hFFFF_FFF8;
        restart_stream(32'hFFFF_FFF8);
        tick; bus.jump_valid = 1'b0;
        repeat (8) tick;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            tick;
            bus.jump_valid = 1'b0;
            rst            = 1'b0;
            bus.out_ready  = ($urandom_range(0, 9) < 7);
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                case ($urandom_range(0, 2))
                    0:       tgt = {4'h4, 16'h0, 12'($urandom)};
                    1:       tgt = {4'h1, 14'h0, 14'($urandom)};
                    default: tgt = {4'h7, 28'($urandom)};
                endcase
                bus.jump_valid = 1'b1;
                bus.jump_addr  = tgt;
                restart_stream(tgt);
            end else if (r == 4) begin
                rst = 1'b1;
                restart_stream(RST_PC);
            end
        end

        // Drain with decode always ready
        tick;
        bus.jump_valid = 1'b0;
        rst            = 1'b0;
        bus.out_ready  = 1'b1;
        repeat (10) tick;
        @(negedge clk);
        chk("drain_out_valid", 32'(bus.out_valid), 32'd1);
        checks++;
        if (pops < 200) begin
            errors++;
            $display("FAIL progress accepted=%0d required>=200", pops);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
